// File: rtl/cwc_capture_reader.sv
// Reads a circular capture RAM oldest-sample-first and streams it as a byte frame.
// Frame layout: 0xA5, count[hi], count[lo], then ceil(DATA_W/8) bytes per sample, MSB first.
module cwc_capture_reader #(
    parameter int DATA_W = 107,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   trig_addr,
    input  logic [ADDR_W:0]     sample_count,
    output logic                ram_rd_en,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    input  logic [DATA_W-1:0]   ram_rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_last,
    output logic                busy,
    output logic                done
);

    localparam int NB    = (DATA_W + 7) / 8;
    localparam int SH_W  = NB * 8;
    localparam int BI_W  = $clog2(NB + 1);
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]  ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ZERO_CNT  = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [BI_W-1:0]   ONE_BI    = {{(BI_W-1){1'b0}}, 1'b1};
    localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(NB - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [1:0]          hdr_idx_r, hdr_idx_s;
    logic [BI_W-1:0]     byte_idx_r, byte_idx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [CNT_W-1:0]    remain_r, remain_s;
    logic [ADDR_W-1:0]   rd_ptr_r, rd_ptr_s;
    logic [SH_W-1:0]     shift_r, shift_s;
    logic [7:0]          tx_data_r, tx_data_s;
    logic                tx_valid_r, tx_valid_s;
    logic                tx_last_r, tx_last_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                ram_rd_en_r, ram_rd_en_s;
    logic [ADDR_W-1:0]   ram_rd_addr_r, ram_rd_addr_s;

    logic                xfer_s;
    logic [CNT_W-1:0]    cnt_in_s;
    logic [15:0]         cnt_ext_s;

    assign xfer_s    = tx_valid_r & tx_ready;
    assign cnt_in_s  = (sample_count > DEPTH) ? DEPTH : sample_count;
    assign cnt_ext_s = {{(16-CNT_W){1'b0}}, cnt_r};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_HDR;
                else       state_s = ST_IDLE;
            end
            ST_HDR: begin
                if (xfer_s && (hdr_idx_r == 2'd2)) state_s = (cnt_r == ZERO_CNT) ? ST_DONE : ST_FETCH;
                else                                state_s = ST_HDR;
            end
            ST_FETCH: state_s = ST_WAIT;
            ST_WAIT:  state_s = ST_SEND;
            ST_SEND: begin
                if (xfer_s && (byte_idx_r == LAST_BYTE)) state_s = (remain_r == ONE_CNT) ? ST_DONE : ST_FETCH;
                else                                     state_s = ST_SEND;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered below
    always_comb begin
        hdr_idx_s  = hdr_idx_r;
        byte_idx_s = byte_idx_r;
        cnt_s      = cnt_r;
        remain_s   = remain_r;
        rd_ptr_s   = rd_ptr_r;
        shift_s    = shift_r;
        tx_data_s  = tx_data_r;
        tx_valid_s = tx_valid_r;
        tx_last_s  = tx_last_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    cnt_s      = cnt_in_s;
                    remain_s   = cnt_in_s;
                    rd_ptr_s   = trig_addr + ONE_ADDR;
                    hdr_idx_s  = 2'd0;
                    tx_data_s  = 8'hA5;
                    tx_valid_s = 1'b1;
                    tx_last_s  = 1'b0;
                    busy_s     = 1'b1;
                end else begin
                    busy_s     = 1'b0;
                end
            end
            ST_HDR: begin
                if (xfer_s) begin
                    hdr_idx_s = hdr_idx_r + 2'd1;
                    case (hdr_idx_r)
                        2'd0: tx_data_s = cnt_ext_s[15:8];
                        2'd1: begin
                            tx_data_s = cnt_ext_s[7:0];
                            tx_last_s = (cnt_r == ZERO_CNT);
                        end
                        default: begin
                            tx_valid_s = 1'b0;
                            tx_last_s  = 1'b0;
                        end
                    endcase
                end else begin
                    hdr_idx_s = hdr_idx_r;
                end
            end
            ST_WAIT: begin
                // The RAM word arrives this cycle; pad at the MSB end and present its top byte
                shift_s                = {SH_W{1'b0}};
                shift_s[DATA_W-1:0]    = ram_rd_data;
                byte_idx_s             = {BI_W{1'b0}};
                tx_data_s              = shift_s[SH_W-1 -: 8];
                tx_valid_s             = 1'b1;
                tx_last_s              = (remain_r == ONE_CNT) && (byte_idx_s == LAST_BYTE);
            end
            ST_SEND: begin
                if (xfer_s && (byte_idx_r == LAST_BYTE)) begin
                    byte_idx_s = {BI_W{1'b0}};
                    rd_ptr_s   = rd_ptr_r + ONE_ADDR;
                    remain_s   = remain_r - ONE_CNT;
                    tx_valid_s = 1'b0;
                    tx_last_s  = 1'b0;
                end else if (xfer_s) begin
                    byte_idx_s = byte_idx_r + ONE_BI;
                    shift_s    = {shift_r[SH_W-9:0], 8'h00};
                    tx_data_s  = shift_s[SH_W-1 -: 8];
                    tx_last_s  = (remain_r == ONE_CNT) && (byte_idx_s == LAST_BYTE);
                end else begin
                    byte_idx_s = byte_idx_r;
                end
            end
            ST_FETCH: tx_valid_s = 1'b0;
            ST_DONE:  tx_valid_s = 1'b0;
            default: begin
                tx_valid_s = 1'b0;
                tx_last_s  = 1'b0;
            end
        endcase
        if (state_s == ST_DONE) begin
            done_s = 1'b1;
            busy_s = 1'b0;
        end else begin
            done_s = 1'b0;
        end
        ram_rd_en_s = (state_s == ST_FETCH);
        if (state_s == ST_FETCH) ram_rd_addr_s = rd_ptr_s;
        else                     ram_rd_addr_s = ram_rd_addr_r;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_idx_r     <= 2'd0;
            byte_idx_r    <= {BI_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            remain_r      <= {CNT_W{1'b0}};
            rd_ptr_r      <= {ADDR_W{1'b0}};
            shift_r       <= {SH_W{1'b0}};
            tx_data_r     <= 8'h00;
            tx_valid_r    <= 1'b0;
            tx_last_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            ram_rd_en_r   <= 1'b0;
            ram_rd_addr_r <= {ADDR_W{1'b0}};
        end else begin
            hdr_idx_r     <= hdr_idx_s;
            byte_idx_r    <= byte_idx_s;
            cnt_r         <= cnt_s;
            remain_r      <= remain_s;
            rd_ptr_r      <= rd_ptr_s;
            shift_r       <= shift_s;
            tx_data_r     <= tx_data_s;
            tx_valid_r    <= tx_valid_s;
            tx_last_r     <= tx_last_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            ram_rd_en_r   <= ram_rd_en_s;
            ram_rd_addr_r <= ram_rd_addr_s;
        end
    end

    assign tx_data     = tx_data_r;
    assign tx_valid    = tx_valid_r;
    assign tx_last     = tx_last_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign ram_rd_en   = ram_rd_en_r;
    assign ram_rd_addr = ram_rd_addr_r;

endmodule

// File: doc/cwc_capture_reader.md
CWC_CAPTURE_READER -- requirements
Module: cwc_capture_reader

Interface
REQ-001 Parameter DATA_W, default 107, width of one captured sample word (sum of all probe widths).
REQ-002 Parameter ADDR_W, default 10, capture RAM address width; depth = 2**ADDR_W = 1024.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  single-cycle readout request.
REQ-006 trig_addr  in  ADDR_W  RAM address of the last written sample; sampled on accepted start.
REQ-007 sample_count  in  ADDR_W+1  number of samples to read; sampled on accepted start.
REQ-008 ram_rd_en  out  1  capture RAM read strobe.
REQ-009 ram_rd_addr  out  ADDR_W  capture RAM read address.
REQ-010 ram_rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after ram_rd_en.
REQ-011 tx_data  out  8  output byte.
REQ-012 tx_valid  out  1  tx_data valid.
REQ-013 tx_ready  in  1  downstream accepts byte.
REQ-014 tx_last  out  1  marks final byte of frame.
REQ-015 busy  out  1  high from accepted start until the final byte is accepted.
REQ-016 done  out  1  one-cycle pulse after the final byte.

Function
REQ-017 FSM states: IDLE, HDR, FETCH, WAIT, SEND, DONE.
REQ-018 start is accepted only in IDLE; start in any other state is ignored.
REQ-019 On accepted start: latch cnt = min(sample_count, 1024); set rd_ptr = trig_addr + 1 mod 1024 (oldest sample first); enter HDR; busy=1.
REQ-020 HDR sends 3 bytes in order: 0xA5, cnt[10:8] zero-extended, cnt[7:0]; first header byte is presented with tx_valid=1 on the cycle after start.
REQ-021 Byte transfer occurs only on the cycle tx_valid & tx_ready; while tx_valid=1 and tx_ready=0, tx_data and tx_last are held stable and tx_valid stays 1.
REQ-022 After the third header byte: if cnt=0, that byte carries tx_last=1 and the FSM goes to DONE; otherwise it goes to FETCH.
REQ-023 FETCH asserts ram_rd_en=1 with ram_rd_addr=rd_ptr for exactly one cycle, then WAIT for one cycle; ram_rd_data is captured into a DATA_W shift register at the end of WAIT.
REQ-024 SEND emits NB = ceil(DATA_W/8) = 14 bytes per sample, MSB first; the word is zero-padded at the MSB end to NB*8 bits.
REQ-025 After the last byte of a sample: rd_ptr increments and wraps 1023->0; remaining count decrements; FSM returns to FETCH if count > 0, else goes to DONE.
REQ-026 tx_last=1 only on the final byte of the frame; frame length = 3 + 14*cnt bytes.
REQ-027 DONE lasts one cycle: done=1, busy=0; then IDLE. start in DONE is ignored.
REQ-028 ram_rd_en is never asserted outside FETCH; tx_valid=0 in IDLE, FETCH, WAIT, DONE.

Reset
REQ-029 On rst_n=0, immediately: state=IDLE; tx_valid, tx_last, busy, done, ram_rd_en=0; tx_data, ram_rd_addr, internal counters=0.
REQ-030 Reset mid-frame abandons the frame without emitting tx_last; the first start after rst_n deasserts begins a fresh frame.

Verification
REQ-031 trig_addr=5, sample_count=2, tx_ready=1 -> bytes A5,00,02; reads at 6 then 7; 31 bytes total; tx_last on byte 31; done pulses once.
REQ-032 trig_addr=1023, sample_count=2 -> reads at addresses 0 then 1 (wrap).
REQ-033 sample_count=0 -> A5,00,00 with tx_last on the third byte; no ram_rd_en; done pulses.
REQ-034 sample_count=1500 -> header 04,00; 1024 reads; 14339 bytes.
REQ-035 Random tx_ready stalls and a start pulse during busy -> byte stream identical to the no-stall case; second start ignored.
REQ-036 rst_n pulled low during SEND -> all outputs 0 in the same cycle; a new start afterwards yields a correct frame.
